encoder_al_16_4_rr: RTL
=======================

Name: encoder_al_16_4_rr

Overview:
- Sequential 16-to-4 request encoder; the inverse of the team's 4-to-16 active-low-enable decoder.
- Captures sticky request events on 16 lines and encodes one pending line at a time into a 4-bit index.
- Presents the index with a valid/ack handshake and clears the served line on ack.
- Sits between peripheral event lines and the controller that drives the 4-16 decoder select.

Parameters:
- N_REQ, 16, number of request lines (power of two, 2..16).
- CODE_W, 4, index width; must equal log2(N_REQ).
- RR_EN, 1, selection policy: 1 = round-robin starting after the last served index; 0 = fixed priority, lowest index wins.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- en_in  input  1  active-low enable: 0 = block enabled.
- req_in  input  N_REQ  request event lines; a high level in a cycle marks that line pending.
- ack_in  input  1  consumer accepts the presented code.
- code_out  output  CODE_W  encoded index of the served line.
- valid_out  output  1  code_out is valid.
- pend_out  output  N_REQ  current pending register (debug/status).
- any_out  output  1  OR of the pending register.

Behaviour:
- Reset (async, rst_in=1):
  - pend=0, code_out=0, valid_out=0, any_out=0.
  - Round-robin pointer = N_REQ-1, so the first RR search starts at index 0.
- Capture:
  - While en_in=0, each edge does pend |= req_in.
  - While en_in=1, req_in is ignored.
- Ack clear: when valid_out=1 and ack_in=1 at an edge, clear pend[code_out] and drive valid_out=0 for that next cycle.
- Same bit set and cleared in one edge: set wins, and the bit stays pending.
- Load: on an edge where valid_out=0, en_in=0 and the pre-edge pend is nonzero:
  - Load code_out with the selected index and set valid_out=1.
  - Selection uses pend before this edge's capture.
  - Latency: req_in high at edge k, pend set at edge k, valid_out=1 after edge k+1 at the earliest.
- Holding: while valid_out=1 and ack_in=0, code_out and valid_out are held stable, whatever en_in, req_in or pend do.
- Disable mid-transfer: with en_in=1, a presented code stays valid until acked, then no new load happens until en_in returns to 0. Pending bits are retained.
- No back-to-back: after an ack, valid_out is 0 for at least one cycle. Maximum throughput is one code per 2 cycles.
- RR selection (RR_EN=1):
  - Pick the first set pend bit scanning from (ptr+1) mod N_REQ upward with wrap-around.
  - ptr updates to code_out on ack, not on load.
- Fixed selection (RR_EN=0): the lowest set pend bit; ptr is unused.
- ack_in while valid_out=0 is ignored.
- any_out = |pend, registered view (same cycle as pend_out).
- Reset mid-operation clears everything immediately; no handshake completes.

Decomposition:
- Shared package (enc_dec_pkg):
  - Constants N_REQ_DEF=16, CODE_W_DEF=4.
  - A one-hot-to-index function shared with the decoder testbench.
- One natural sub-module: rr_pick, combinational, taking pend plus ptr and returning index plus found. It implements both policies via RR_EN.
- Top level holds the pend, code, valid and ptr registers.

Test Plan:
1. Reset then idle -> valid_out=0, code_out=0, pend_out=0 for 10 cycles; assert rst_in mid-hold -> all outputs 0 asynchronously.
2. Single pulse req_in=16'h0020 for 1 cycle, ack_in=1 -> valid_out=1 with code_out=5 two edges later; after ack, pend_out=0 and valid_out=0.
3. RR: req_in=16'h8101 held 1 cycle, ack_in=1 continuously -> codes 0, 8, 15 in order, then valid_out stays 0; with RR_EN=0 the order is the same. Then set 16'h0003 again after serving 0 under RR -> order 1, 0.
4. Hold: valid_out=1 with code 3 and ack_in=0 for 5 cycles while req_in=16'h0001 pulses -> code_out stays 3; after ack the next code is 0.
5. Set/clear collision: req_in bit 3 high on the same edge as the ack of code 3 -> pend_out[3] remains 1 and code 3 is re-presented.
6. en_in=1 with req_in=16'hFFFF -> pend_out unchanged; en_in=1 while code 2 is presented -> code 2 holds until acked, then no load until en_in=0.

Source files
------------

// File: rtl/enc_dec_pkg.sv
// rtl/enc_dec_pkg.sv - shared constants and helpers for the 4-16 decoder / 16-4 encoder pair
package enc_dec_pkg;

   localparam int N_REQ_DEF  = 16;
   localparam int CODE_W_DEF = 4;

   typedef logic [N_REQ_DEF-1:0]  req_vec_t;
   typedef logic [CODE_W_DEF-1:0] code_t;

   // Index of the lowest set bit; a true one-hot input yields its position, zero yields 0.
   function automatic code_t onehot_to_index(input req_vec_t oh);
      code_t idx;
      idx = '0;
      for (int i = N_REQ_DEF - 1; i >= 0; i--) begin
         if (oh[i]) idx = code_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational selector: round-robin after ptr, or lowest index first
module rr_pick #(
   parameter int N_REQ  = 16,
   parameter int CODE_W = 4,
   parameter bit RR_EN  = 1'b1
) (
   input  logic [N_REQ-1:0]  pend,
   input  logic [CODE_W-1:0] ptr,
   output logic [CODE_W-1:0] idx,
   output logic              found
);

   logic [CODE_W-1:0] cand;

   // N_REQ is a power of two, so CODE_W-bit truncation gives the wrap-around for free.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = RR_EN ? CODE_W'(ptr + CODE_W'(1) + CODE_W'(k)) : CODE_W'(k);
         if (!found && pend[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/encoder_al_16_4_rr.sv
// rtl/encoder_al_16_4_rr.sv - sticky 16-to-4 request encoder with valid/ack handshake
module encoder_al_16_4_rr
   import enc_dec_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int CODE_W = CODE_W_DEF,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              en_in,
   input  logic [N_REQ-1:0]  req_in,
   input  logic              ack_in,
   output logic [CODE_W-1:0] code_out,
   output logic              valid_out,
   output logic [N_REQ-1:0]  pend_out,
   output logic              any_out
);

   logic [N_REQ-1:0]  pend;
   logic [N_REQ-1:0]  capture;
   logic [N_REQ-1:0]  clr;
   logic [CODE_W-1:0] code;
   logic [CODE_W-1:0] ptr;
   logic [CODE_W-1:0] pick_idx;
   logic              pick_found;
   logic              valid;
   logic              take;
   logic              load;

   rr_pick #(
      .N_REQ  (N_REQ),
      .CODE_W (CODE_W),
      .RR_EN  (RR_EN)
   ) u_pick (
      .pend  (pend),
      .ptr   (ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign take    = valid & ack_in;
   assign load    = ~valid & ~en_in & pick_found;
   assign capture = en_in ? '0 : req_in;
   assign clr     = take ? (N_REQ'(1) << code) : '0;

   // Capture is OR-ed after the clear so a same-edge re-request keeps the bit pending.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pend  <= '0;
         code  <= '0;
         valid <= 1'b0;
         ptr   <= CODE_W'(N_REQ - 1);
      end else begin
         pend <= (pend & ~clr) | capture;
         if (take) begin
            valid <= 1'b0;
            ptr   <= code;
         end else if (load) begin
            valid <= 1'b1;
            code  <= pick_idx;
         end
      end
   end

   assign code_out  = code;
   assign valid_out = valid;
   assign pend_out  = pend;
   assign any_out   = |pend;

endmodule
